apb_fpu_sequencer: RTL and testbench

APB slave controller for the floating-point add/sub unit. It runs entirely in the system_clk domain and advances APB transfers only on the one-cycle rising-edge strobe produced by the APB clock edge detector. It holds the operand and control registers, launches each add/sub operation, waits for completion with a timeout, and returns result and status over APB.

---
 rtl/apb_fpu_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_apb_fpu_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_fpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : apb_fpu_sequencer
//  Purpose  : APB slave that holds the operands and control of a floating-point
//             add/sub unit. It launches one operation at a time, waits for
//             completion with a timeout, and returns the result and status
//             over APB. APB transfers advance only on apb_edge strobes, and
//             everything runs in the system_clk domain.
//  Ports    : system_clk, nrst (async, active-low)
//             apb_edge, psel, penable, pwrite, paddr, pwdata -> APB request
//             prdata, pready, pslverr                       -> APB response (registered)
//             fpu_start, fpu_sub, fpu_a, fpu_b              -> add/sub unit command
//             fpu_result, fpu_done, fpu_ovf                 <- add/sub unit completion
//  Revision : 1.0 - initial release
// ============================================================================
module apb_fpu_sequencer #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 5,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              system_clk,
   input  logic              nrst,
   input  logic              apb_edge,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [DATA_W-1:0] pwdata,
   output logic [DATA_W-1:0] prdata,
   output logic              pready,
   output logic              pslverr,
   output logic              fpu_start,
   output logic              fpu_sub,
   output logic [DATA_W-1:0] fpu_a,
   output logic [DATA_W-1:0] fpu_b,
   input  logic [DATA_W-1:0] fpu_result,
   input  logic              fpu_done,
   input  logic              fpu_ovf
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [ADDR_W-1:0] c_ADDR_OPA    = ADDR_W'(8'h00);
   localparam logic [ADDR_W-1:0] c_ADDR_OPB    = ADDR_W'(8'h04);
   localparam logic [ADDR_W-1:0] c_ADDR_CTRL   = ADDR_W'(8'h08);
   localparam logic [ADDR_W-1:0] c_ADDR_STATUS = ADDR_W'(8'h0C);
   localparam logic [ADDR_W-1:0] c_ADDR_RESULT = ADDR_W'(8'h10);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_opa;
   logic [DATA_W-1:0] r_opb;
   logic [DATA_W-1:0] r_result;
   logic [DATA_W-1:0] r_prdata;
   logic              r_pready;
   logic              r_pslverr;
   logic              r_start;
   logic              r_sub;
   logic              r_busy;
   logic              r_done;
   logic              r_ovf;
   logic              r_err;
   logic              r_stall;    // a RESULT read is parked until busy falls

   logic              w_setup;
   logic              w_access;
   logic              w_hit_opa;
   logic              w_hit_opb;
   logic              w_hit_ctrl;
   logic              w_hit_status;
   logic              w_hit_result;
   logic              w_mapped;
   logic              w_hit_rw;
   logic              w_wr_ok;
   logic              w_start_acc;
   logic              w_timeout;
   logic              w_finish;
   logic [DATA_W-1:0] w_fin_result;
   logic [DATA_W-1:0] w_rdata;

   assign w_setup      = apb_edge & psel & ~penable;
   assign w_access     = apb_edge & psel & penable & r_pready;

   assign w_hit_opa    = (paddr == c_ADDR_OPA);
   assign w_hit_opb    = (paddr == c_ADDR_OPB);
   assign w_hit_ctrl   = (paddr == c_ADDR_CTRL);
   assign w_hit_status = (paddr == c_ADDR_STATUS);
   assign w_hit_result = (paddr == c_ADDR_RESULT);
   assign w_mapped     = w_hit_opa | w_hit_opb | w_hit_ctrl | w_hit_status | w_hit_result;
   assign w_hit_rw     = w_hit_opa | w_hit_opb | w_hit_ctrl;

   // A write flagged as an error in the setup phase never touches a register.
   assign w_wr_ok      = w_access & pwrite & ~r_pslverr & ~r_busy;
   assign w_start_acc  = w_wr_ok & w_hit_ctrl & pwdata[0];

   // A real completion beats a timeout that lands in the same cycle.
   assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign w_finish     = (r_state == S_WAIT) & (fpu_done | w_timeout);
   assign w_fin_result = fpu_done ? fpu_result : '0;

   always_comb begin
      w_rdata = '0;
      if (w_hit_opa)         w_rdata = r_opa;
      else if (w_hit_opb)    w_rdata = r_opb;
      else if (w_hit_ctrl)   w_rdata = {{(DATA_W-2){1'b0}}, r_sub, 1'b0};
      else if (w_hit_status) w_rdata = {{(DATA_W-4){1'b0}}, r_err, r_ovf, r_done, r_busy};
      else if (w_hit_result) w_rdata = r_result;
   end

   // APB handling comes first and the sequencer second, so that a completion
   // flag set in the same cycle as a STATUS-read clear takes priority.
   always_ff @(posedge system_clk or negedge nrst) begin
      if (!nrst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_opa     <= '0;
         r_opb     <= '0;
         r_result  <= '0;
         r_prdata  <= '0;
         r_pready  <= 1'b1;
         r_pslverr <= 1'b0;
         r_start   <= 1'b0;
         r_sub     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_ovf     <= 1'b0;
         r_err     <= 1'b0;
         r_stall   <= 1'b0;
      end else begin
         r_start <= 1'b0;

         if (w_setup) begin
            if (!pwrite) begin
               r_prdata <= w_rdata;
            end
            r_pready  <= ~(~pwrite & w_hit_result & r_busy);
            r_stall   <= ~pwrite & w_hit_result & r_busy;
            r_pslverr <= ~w_mapped | (pwrite & w_hit_rw & r_busy);
         end

         if (w_access) begin
            r_pslverr <= 1'b0;
            if (w_wr_ok && w_hit_opa) begin
               r_opa <= pwdata;
            end
            if (w_wr_ok && w_hit_opb) begin
               r_opb <= pwdata;
            end
            if (!pwrite && w_hit_status) begin
               r_done <= 1'b0;
               r_ovf  <= 1'b0;
               r_err  <= 1'b0;
            end
         end

         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_start_acc) begin
                  r_state <= S_START;
                  r_start <= 1'b1;
                  r_busy  <= 1'b1;
                  r_sub   <= pwdata[1];
                  r_done  <= 1'b0;
                  r_ovf   <= 1'b0;
                  r_err   <= 1'b0;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_START: begin
               r_state <= S_WAIT;
               r_cnt   <= '0;
            end
            S_WAIT: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_finish) begin
                  r_state  <= S_DONE;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_result <= w_fin_result;
                  if (fpu_done) begin
                     r_ovf <= fpu_ovf;
                  end else begin
                     r_err <= 1'b1;
                  end
                  // Release a parked RESULT read with the fresh value.
                  if (r_stall) begin
                     r_prdata <= w_fin_result;
                     r_pready <= 1'b1;
                     r_stall  <= 1'b0;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign prdata    = r_prdata;
   assign pready    = r_pready;
   assign pslverr   = r_pslverr;
   assign fpu_start = r_start;
   assign fpu_sub   = r_sub;
   assign fpu_a     = r_opa;
   assign fpu_b     = r_opb;

endmodule
`default_nettype wire

// File: tb/tb_apb_fpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_fpu_sequencer
//  Purpose  : Self-checking bench for apb_fpu_sequencer: a register-access
//             vector table followed by directed multi-cycle sequences, with a
//             behavioural add/sub unit stub answering each fpu_start.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_fpu_sequencer;

   logic        system_clk;
   logic        nrst;
   logic        apb_edge;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [4:0]  paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;
   logic        fpu_start;
   logic        fpu_sub;
   logic [31:0] fpu_a;
   logic [31:0] fpu_b;
   logic [31:0] fpu_result;
   logic        fpu_done;
   logic        fpu_ovf;

   apb_fpu_sequencer #(
      .DATA_W         (32),
      .ADDR_W         (5),
      .TIMEOUT_CYCLES (64)
   ) u_dut (
      .system_clk (system_clk),
      .nrst       (nrst),
      .apb_edge   (apb_edge),
      .psel       (psel),
      .penable    (penable),
      .pwrite     (pwrite),
      .paddr      (paddr),
      .pwdata     (pwdata),
      .prdata     (prdata),
      .pready     (pready),
      .pslverr    (pslverr),
      .fpu_start  (fpu_start),
      .fpu_sub    (fpu_sub),
      .fpu_a      (fpu_a),
      .fpu_b      (fpu_b),
      .fpu_result (fpu_result),
      .fpu_done   (fpu_done),
      .fpu_ovf    (fpu_ovf)
   );

   initial begin
      system_clk = 1'b0;
      forever #5 system_clk = ~system_clk;
   end

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;
   int t_start = 0;
   int t_rdy   = 0;
   int n_start = 0;

   // Stub configuration: delay 0 means the unit never answers.
   int          stub_delay = 0;
   logic [31:0] stub_res   = 32'h0;
   logic        stub_ovf   = 1'b0;

   initial forever begin
      @(posedge system_clk);
      cyc++;
   end

   // Records the cycle in which pready rises (release of a stalled read).
   logic prev_rdy = 1'b1;
   initial forever begin
      @(negedge system_clk);
      if (pready === 1'b1 && prev_rdy === 1'b0) t_rdy = cyc;
      prev_rdy = pready;
   end

   initial begin
      fpu_done   = 1'b0;
      fpu_result = 32'h0;
      fpu_ovf    = 1'b0;
      forever begin
         @(negedge system_clk);
         if (fpu_start === 1'b1) begin
            n_start++;
            t_start = cyc;
            if (stub_delay > 0) begin
               repeat (stub_delay) @(negedge system_clk);
               fpu_done   = 1'b1;
               fpu_result = stub_res;
               fpu_ovf    = stub_ovf;
               @(negedge system_clk);
               fpu_done   = 1'b0;
               fpu_result = 32'h0;
               fpu_ovf    = 1'b0;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // One APB transfer: a setup strobe, a gap cycle, then access strobes until
   // a strobe finds pready high. Returns the response seen on that strobe.
   task automatic apb(input logic wr, input logic [4:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int waits);
      logic rdy;
      waits = 0;
      rd    = 32'h0;
      er    = 1'b0;
      @(negedge system_clk);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; apb_edge = 1'b1;
      @(negedge system_clk);
      apb_edge = 1'b0;
      @(negedge system_clk);
      penable = 1'b1;
      forever begin
         rdy = pready;
         rd  = prdata;
         er  = pslverr;
         apb_edge = 1'b1;
         @(negedge system_clk);
         apb_edge = 1'b0;
         if (rdy === 1'b1) break;
         waits++;
         if (waits >= 200) begin
            n_vec++;
            n_miss++;
            $display("FAIL apb_timeout: addr %h still not ready after %0d strobes", a, waits);
            break;
         end
         @(negedge system_clk);
      end
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   typedef struct {
      logic        wr;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t tbl[13];

   logic [31:0] rd;
   logic        er;
   int          w;
   int          s0;

   initial begin
      tbl[0]  = '{1'b1, 5'h00, 32'h3F800000, 32'h0,        1'b0};
      tbl[1]  = '{1'b1, 5'h04, 32'h40000000, 32'h0,        1'b0};
      tbl[2]  = '{1'b0, 5'h00, 32'h0,        32'h3F800000, 1'b0};
      tbl[3]  = '{1'b0, 5'h04, 32'h0,        32'h40000000, 1'b0};
      tbl[4]  = '{1'b0, 5'h08, 32'h0,        32'h0,        1'b0};
      tbl[5]  = '{1'b0, 5'h0C, 32'h0,        32'h0,        1'b0};
      tbl[6]  = '{1'b0, 5'h10, 32'h0,        32'h0,        1'b0};
      tbl[7]  = '{1'b1, 5'h14, 32'hDEADBEEF, 32'h0,        1'b1};
      tbl[8]  = '{1'b0, 5'h00, 32'h0,        32'h3F800000, 1'b0};
      tbl[9]  = '{1'b0, 5'h14, 32'h0,        32'h0,        1'b1};
      tbl[10] = '{1'b0, 5'h02, 32'h0,        32'h0,        1'b1};
      tbl[11] = '{1'b1, 5'h0C, 32'h0000000F, 32'h0,        1'b0};
      tbl[12] = '{1'b0, 5'h0C, 32'h0,        32'h0,        1'b0};

      nrst = 1'b0; apb_edge = 1'b0; psel = 1'b0; penable = 1'b0;
      pwrite = 1'b0; paddr = 5'h0; pwdata = 32'h0;
      repeat (3) @(negedge system_clk);
      chk("rst_prdata",  prdata,    32'h0);
      chk("rst_pready",  {31'b0, pready},    32'h1);
      chk("rst_pslverr", {31'b0, pslverr},   32'h0);
      chk("rst_start",   {31'b0, fpu_start}, 32'h0);
      chk("rst_sub",     {31'b0, fpu_sub},   32'h0);
      nrst = 1'b1;
      @(negedge system_clk);

      // Register access table.
      for (int i = 0; i < 13; i++) begin
         apb(tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd, er, w);
         if (!tbl[i].wr) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
         chk($sformatf("tbl%0d_err", i), {31'b0, er}, {31'b0, tbl[i].exp_err});
      end

      // Basic add with a 5-cycle unit.
      stub_delay = 5; stub_res = 32'h40400000; stub_ovf = 1'b0;
      s0 = n_start;
      apb(1'b1, 5'h08, 32'h1, rd, er, w);
      chk("add_ctrl_err", {31'b0, er}, 32'h0);
      chk("add_fpu_a", fpu_a, 32'h3F800000);
      chk("add_fpu_b", fpu_b, 32'h40000000);
      repeat (30) @(negedge system_clk);
      chk("add_starts", 32'(n_start - s0), 32'h1);
      chk("add_sub", {31'b0, fpu_sub}, 32'h0);
      apb(1'b0, 5'h0C, 32'h0, rd, er, w);
      chk("add_status", rd, 32'h2);
      apb(1'b0, 5'h10, 32'h0, rd, er, w);
      chk("add_result", rd, 32'h40400000);
      apb(1'b0, 5'h0C, 32'h0, rd, er, w);
      chk("add_status2", rd, 32'h0);

      // Subtract with a RESULT read stalled behind a 20-cycle unit.
      stub_delay = 20; stub_res = 32'hBF800000;
      apb(1'b1, 5'h08, 32'h3, rd, er, w);
      chk("sub_flag_early", {31'b0, fpu_sub}, 32'h1);
      apb(1'b0, 5'h10, 32'h0, rd, er, w);
      chk("stall_rdata", rd, 32'hBF800000);
      chk("stall_waited", {31'b0, (w >= 3)}, 32'h1);
      chk("stall_latency", 32'(t_rdy - t_start), 32'd21);
      chk("sub_flag_late", {31'b0, fpu_sub}, 32'h1);
      apb(1'b0, 5'h08, 32'h0, rd, er, w);
      chk("ctrl_readback", rd, 32'h2);
      apb(1'b0, 5'h0C, 32'h0, rd, er, w);
      chk("sub_status", rd, 32'h2);

      // Writes while busy are refused.
      stub_delay = 20; stub_res = 32'h1;
      apb(1'b1, 5'h08, 32'h1, rd, er, w);
      apb(1'b1, 5'h00, 32'hDEADBEEF, rd, er, w);
      chk("busy_wr_err", {31'b0, er}, 32'h1);
      chk("busy_wr_opa", fpu_a, 32'h3F800000);
      apb(1'b0, 5'h0C, 32'h0, rd, er, w);
      chk("busy_status", rd, 32'h1);
      repeat (40) @(negedge system_clk);
      apb(1'b0, 5'h0C, 32'h0, rd, er, w);
      chk("busy_done_status", rd, 32'h2);

      // Unit never answers: timeout after 64 WAIT cycles.
      stub_delay = 0;
      apb(1'b1, 5'h08, 32'h1, rd, er, w);
      apb(1'b0, 5'h10, 32'h0, rd, er, w);
      chk("tmo_result", rd, 32'h0);
      chk("tmo_latency", 32'(t_rdy - t_start), 32'd65);
      apb(1'b0, 5'h0C, 32'h0, rd, er, w);
      chk("tmo_status", rd, 32'hA);
      apb(1'b0, 5'h0C, 32'h0, rd, er, w);
      chk("tmo_status_clr", rd, 32'h0);

      // Reset in the middle of WAIT; the late fpu_done must be ignored.
      stub_delay = 30; stub_res = 32'h55555555;
      apb(1'b1, 5'h08, 32'h3, rd, er, w);
      apb(1'b0, 5'h00, 32'h0, rd, er, w);
      chk("pre_rst_prdata", prdata, 32'h3F800000);
      repeat (4) @(negedge system_clk);
      nrst = 1'b0;
      #1;
      chk("mid_rst_prdata", prdata, 32'h0);
      chk("mid_rst_pready", {31'b0, pready}, 32'h1);
      chk("mid_rst_sub",    {31'b0, fpu_sub}, 32'h0);
      chk("mid_rst_opa",    fpu_a, 32'h0);
      repeat (2) @(negedge system_clk);
      nrst = 1'b1;
      repeat (40) @(negedge system_clk);
      apb(1'b0, 5'h0C, 32'h0, rd, er, w);
      chk("post_rst_status", rd, 32'h0);
      apb(1'b0, 5'h10, 32'h0, rd, er, w);
      chk("post_rst_result", rd, 32'h0);

      // Bus held active with no apb_edge strobes: nothing may move.
      apb(1'b1, 5'h00, 32'h11111111, rd, er, w);
      s0 = n_start;
      @(negedge system_clk);
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 5'h00; pwdata = 32'hCAFEF00D;
      repeat (5) @(negedge system_clk);
      paddr = 5'h08; pwdata = 32'h1;
      repeat (5) @(negedge system_clk);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      chk("hold_opa", fpu_a, 32'h11111111);
      chk("hold_starts", 32'(n_start - s0), 32'h0);
      apb(1'b0, 5'h0C, 32'h0, rd, er, w);
      chk("hold_status", rd, 32'h0);

      // Overflow reported alongside completion.
      stub_delay = 3; stub_res = 32'h7F800000; stub_ovf = 1'b1;
      apb(1'b1, 5'h08, 32'h1, rd, er, w);
      repeat (20) @(negedge system_clk);
      apb(1'b0, 5'h0C, 32'h0, rd, er, w);
      chk("ovf_status", rd, 32'h6);
      apb(1'b0, 5'h10, 32'h0, rd, er, w);
      chk("ovf_result", rd, 32'h7F800000);
      stub_ovf = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
